aes_inv_key_schedule: RTL

//  Iterative AES-128 inverse key schedule: undoes the forward key expansion step.

---
 rtl/aes_inv_key_schedule_pkg.sv | 63 ++++++
 rtl/aes_inv_key_step.sv | 19 +
 rtl/aes_inv_key_schedule.sv | 86 ++++++++
 3 files changed

// File: rtl/aes_inv_key_schedule_pkg.sv
// Shared AES-128 key-schedule definitions: key type, FSM state type, forward S-box,
// RCON and the RotWord/SubWord helpers used by both key schedule directions.
package aes_inv_key_schedule_pkg;

  localparam int WORD_W    = 32;
  localparam int KEY_WORDS = 4;

  typedef logic [KEY_WORDS-1:0][WORD_W-1:0] key_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Forward S-box; entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_FLAT[(255 - int'(b)) * 8 +: 8];
  endfunction

  // RCON in the top byte; rounds above 10 continue the doubling sequence so NR up to 15 works.
  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      4'd11:   c = 8'h6c;
      4'd12:   c = 8'hd8;
      4'd13:   c = 8'hab;
      4'd14:   c = 8'h4d;
      4'd15:   c = 8'h9a;
      default: c = 8'h00;
    endcase
    return {c, 24'h000000};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One inverse key-expansion step: maps the round-r key to the round r-1 key.
// Purely combinational; holds the four S-box lookups of SubWord.
module aes_inv_key_step
  import aes_inv_key_schedule_pkg::*;
(
  input  key_t       key_i,
  input  logic [3:0] round_i,
  output key_t       key_o
);

  logic [31:0] p3;
  logic [31:0] g;

  // The previous key's last word is recoverable first, and it feeds the g-function for word 0.
  assign p3    = key_i[3] ^ key_i[2];
  assign g     = sub_word(rot_word(p3)) ^ rcon(round_i);
  assign key_o = {p3, key_i[2] ^ key_i[1], key_i[1] ^ key_i[0], key_i[0] ^ g};

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: loaded with the round-NR key, streams round keys
// NR down to 0 over a valid/ready interface, one per accepted beat.
module aes_inv_key_schedule
  import aes_inv_key_schedule_pkg::*;
#(
  parameter int REG_SIZE = 32,
  parameter int VEC_SIZE = 4,
  parameter int NR       = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  last_key,
  output logic                               busy,
  output logic                               rk_valid,
  input  logic                               rk_ready,
  output logic [VEC_SIZE-1:0][REG_SIZE-1:0]  rk_data,
  output logic [3:0]                         rk_round,
  output logic                               rk_last,
  output logic                               done
);

  localparam logic [3:0] NR_L = 4'(NR);

  state_t     state_q, state_d;
  key_t       key_q, key_d, step_key;
  logic [3:0] round_q, round_d;
  logic       done_q, done_d;

  aes_inv_key_step u_step (
    .key_i   (key_q),
    .round_i (round_q),
    .key_o   (step_key)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          key_d   = last_key;
          round_d = NR_L;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = step_key;
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Key register, round counter and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == EMIT);
  assign rk_valid = (state_q == EMIT);
  assign rk_data  = key_q;
  assign rk_round = round_q;
  assign rk_last  = rk_valid & (round_q == 4'd0);
  assign done     = done_q;

endmodule
